// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed seven-segment scanner.
// Steps through N_DIGITS digits, one digit every DIV clocks. Each digit is
// decoded from hex, and can be blanked, blinked or given a decimal point.
// Display inputs are copied into a shadow copy once per frame, so a frame
// never shows a mix of old and new data. All pin outputs are registered.
module seg_scan_ctrl #(
    parameter int N_DIGITS   = 8,
    parameter int DIV        = 100000,
    parameter int BLINK_DIV  = 64,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [4*N_DIGITS-1:0]   dig,
    input  logic [N_DIGITS-1:0]     dp_mask,
    input  logic [N_DIGITS-1:0]     blank_mask,
    input  logic [N_DIGITS-1:0]     blink_mask,
    output logic [N_DIGITS-1:0]     an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_start
);

    localparam int CW = (DIV > 1)       ? $clog2(DIV)       : 1;
    localparam int IW = (N_DIGITS > 1)  ? $clog2(N_DIGITS)  : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [CW-1:0] CNT_LAST   = CW'(DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    // Pin level that means "off"; XOR with this turns active-high into pin polarity.
    localparam logic POL = (ACTIVE_LOW != 0);

    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic [BW-1:0]           blink_cnt;
    logic                    blink_phase;
    logic                    load_pending;
    logic [4*N_DIGITS-1:0]   dig_sh;
    logic [N_DIGITS-1:0]     dp_sh;
    logic [N_DIGITS-1:0]     blank_sh;
    logic [N_DIGITS-1:0]     blink_sh;

    logic                    tick;
    logic                    wrap;
    logic [N_DIGITS-1:0]     onehot;
    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic                    cur_blank;
    logic                    cur_blink;
    logic                    dark;
    logic [N_DIGITS-1:0]     an_act;
    logic [6:0]              seg_act;
    logic                    dp_act;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
            4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
            4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
            4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
        endcase
        return s;
    endfunction

    assign tick = en && (cnt == CNT_LAST);
    assign wrap = tick && (idx == IDX_LAST);

    // Select the shadow data of the digit currently being scanned.
    always_comb begin
        onehot    = '0;
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        cur_blink = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx == IW'(i)) begin
                onehot[i] = 1'b1;
                cur_nib   = dig_sh[4*i +: 4];
                cur_dp    = dp_sh[i];
                cur_blank = blank_sh[i];
                cur_blink = blink_sh[i];
            end
        end
    end

    assign dark    = cur_blank || (cur_blink && blink_phase);
    assign an_act  = dark ? '0 : onehot;
    assign seg_act = dark ? 7'h00 : hex_to_seg(cur_nib);
    assign dp_act  = cur_dp && !dark;

    // Prescaler, digit index, frame snapshot, blink timing and output pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            idx          <= '0;
            blink_cnt    <= '0;
            blink_phase  <= 1'b0;
            load_pending <= 1'b1;
            dig_sh       <= '0;
            dp_sh        <= '0;
            blank_sh     <= '0;
            blink_sh     <= '0;
            frame_start  <= 1'b0;
            an           <= {N_DIGITS{POL}};
            seg          <= {7{POL}};
            dp           <= POL;
        end else if (en) begin
            if (tick) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
            // The first enabled cycle after reset loads the shadow so the
            // opening frame does not wait a full frame for real data.
            if (wrap || load_pending) begin
                dig_sh       <= dig;
                dp_sh        <= dp_mask;
                blank_sh     <= blank_mask;
                blink_sh     <= blink_mask;
                load_pending <= 1'b0;
            end
            if (wrap) begin
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
            frame_start <= wrap;
            an          <= an_act ^ {N_DIGITS{POL}};
            seg         <= seg_act ^ {7{POL}};
            dp          <= dp_act ^ POL;
        end else begin
            frame_start <= 1'b0;
            an          <= {N_DIGITS{POL}};
            seg         <= {7{POL}};
            dp          <= POL;
        end
    end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Parametrised multiplexed seven-segment scanner for the board display path. Successor to the fixed 8-digit nibble selector.
- Owns the refresh timing: digit counter, refresh prescaler and frame-coherent snapshot of the display word.
- Adds hex-to-segment decode, per-digit decimal point, blanking and blinking, selectable output polarity and an enable.
- Drives the anode and segment pins directly.

Parameters:
- N_DIGITS, 8: number of digits scanned (>=1); the display word is 4*N_DIGITS bits.
- DIV, 100000: clock cycles per digit slot (>=1).
- BLINK_DIV, 64: frames per blink half-period (>=1).
- ACTIVE_LOW, 1: 1 = an/seg/dp pins active-low, 0 = active-high.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  scan enable.
- dig  in  4*N_DIGITS  hex nibbles; digit i = dig[4i+3:4i].
- dp_mask  in  N_DIGITS  bit i lights the decimal point of digit i.
- blank_mask  in  N_DIGITS  bit i forces digit i dark.
- blink_mask  in  N_DIGITS  bit i makes digit i blink.
- an  out  N_DIGITS  digit select, one-hot when active.
- seg  out  7  segments {g,f,e,d,c,b,a}.
- dp  out  1  decimal point.
- frame_start  out  1  one-cycle pulse when a frame begins (index returns to 0).

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst); the polarity and synchronicity are fixed.
- Reset values:
  - Prescaler 0, index 0, blink frame counter 0, blink phase 0.
  - Shadow dig and masks 0; load_pending set to 1; frame_start 0.
  - an/seg/dp all inactive: 1s if ACTIVE_LOW, else 0s.
- Prescaler: counts 0..DIV-1 while en=1. tick = (cnt==DIV-1) & en; cnt returns to 0 on tick. DIV=1 gives a tick every enabled cycle. Width is clog2(DIV), minimum 1.
- Index: advances on tick; wraps from N_DIGITS-1 to 0. N_DIGITS=1 keeps index at 0.
- Wrap events: a wrap is a tick with index==N_DIGITS-1.
  - frame_start is registered and is 1 for exactly the cycle after each wrap.
  - With N_DIGITS=1, every tick is a wrap.
- Snapshot: dig, dp_mask, blank_mask and blink_mask are copied into the shadow on a wrap, or on the first enabled cycle while load_pending=1 (which then clears). Input changes mid-frame never appear until the next frame.
- Blink:
  - The frame counter increments on each wrap.
  - When it reaches BLINK_DIV-1 with a wrap, it clears and the phase toggles.
  - A digit is dark if shadow blank_mask[i]=1, or if shadow blink_mask[i]=1 and phase=1.
- Decode (active-high, hex 0..F): 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
- Outputs: registered, one cycle after the index/shadow state they reflect.
  - an: one-hot at the index, or all inactive if the digit is dark.
  - seg: decode of the shadow nibble, or all off if dark.
  - dp: shadow dp_mask[index] & ~dark.
  - ACTIVE_LOW=1 inverts all three.
- en=0: prescaler, index and blink counters hold; no snapshot. an/seg/dp are forced inactive on the next edge; frame_start=0. On re-enable, scanning resumes from the held state.
- Reset mid-frame: everything returns to reset values in the same edge; no partial frame completes.

Test Plan:
- Decode and timing (N_DIGITS=8, DIV=4, ACTIVE_LOW=1, en=1, dig=32'h76543210, masks 0, rst released at cycle 0):
  - From cycle 2, an=8'hFE and seg=7'h40 (~3F) for 4 cycles.
  - Then an=8'hFD and seg=7'h79 (~06).
  - an returns to 8'hFE after 32 cycles; frame_start pulses once per 32 cycles.
- Snapshot coherency: change dig to 32'hFFFFFFFF while index=3.
  - Digits 3..7 still show 3..7.
  - The next frame shows F on all digits (seg=7'h0E).
- Blank/dp: blank_mask=8'h02, dp_mask=8'h01 → digit 0 dp=0 (lit); digit 1 an=8'hFF and seg=7'h7F during its slot.
- Blink (BLINK_DIV=2, blink_mask=8'h01): digit 0 is lit for 2 frames, dark for 2 frames, repeating; other digits stay steady.
- Enable and reset:
  - en=0 for 10 cycles mid-slot: outputs go inactive, then resume at the same digit with the remaining slot count intact.
  - rst asserted mid-frame: an=8'hFF and seg=7'h7F the next cycle; the scan restarts at digit 0.
- Corner parameters: N_DIGITS=1, DIV=1, ACTIVE_LOW=0, dig=4'hA → an=1, seg=7'h77 steady; frame_start high every cycle from cycle 2.
